// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a first-word-fall-through FIFO with per-entry parity/framing flags.
// Entry is written one cycle after the last stop sample; a full FIFO drops the frame and sets sticky overrun.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int PRESC_W    = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          rx,
  input  logic [PRESC_W-1:0]            prescale,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          clr_ovr,
  output logic                          rx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_W);
  localparam int ENT_W = DATA_W + 2;

  localparam logic [TC_W-1:0]  HALF_TICK = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  FULL_TICK = TC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t state, state_n;

  logic rx_meta, rx_s, rx_d;

  logic [PRESC_W-1:0] presc_cnt, presc_cnt_n;
  logic [PRESC_W-1:0] presc_l;
  logic               par_en_l, par_odd_l, two_stop_l;
  logic               latch_cfg;

  logic [TC_W-1:0]    tick_cnt, tick_cnt_n;
  logic [BC_W-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]  shift, shift_n;
  logic               perr, perr_n;
  logic               ferr, ferr_n;
  logic               tick, samp;

  logic               push_vld, push_vld_n;
  logic [ENT_W-1:0]   push_dat, push_dat_n;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ENT_W-1:0]   head;
  logic               pop, push_ok;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Ticks only exist inside a frame; the counter is parked at zero while idle.
  assign tick = (state != IDLE) && (presc_cnt == presc_l);
  assign samp = tick && (tick_cnt == FULL_TICK);

  always_comb begin
    state_n     = state;
    presc_cnt_n = presc_cnt;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    perr_n      = perr;
    ferr_n      = ferr;
    push_vld_n  = 1'b0;
    push_dat_n  = push_dat;
    latch_cfg   = 1'b0;

    if (state != IDLE) begin
      presc_cnt_n = tick ? '0 : presc_cnt + 1'b1;
    end
    if (tick) begin
      tick_cnt_n = tick_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        presc_cnt_n = '0;
        tick_cnt_n  = '0;
        if (rx_d && !rx_s) begin
          state_n   = START;
          latch_cfg = 1'b1;
          bit_cnt_n = '0;
          perr_n    = 1'b0;
          ferr_n    = 1'b0;
        end
      end
      START: begin
        if (tick && (tick_cnt == HALF_TICK)) begin
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (samp) begin
          tick_cnt_n = '0;
          shift_n    = {rx_s, shift[DATA_W-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_n = par_en_l ? PARITY : STOP1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (samp) begin
          tick_cnt_n = '0;
          perr_n     = ((^shift) ^ rx_s) != par_odd_l;
          state_n    = STOP1;
        end
      end
      STOP1: begin
        if (samp) begin
          tick_cnt_n = '0;
          ferr_n     = ferr | ~rx_s;
          if (two_stop_l) begin
            state_n = STOP2;
          end else begin
            state_n    = IDLE;
            push_vld_n = 1'b1;
            push_dat_n = {ferr | ~rx_s, perr, shift};
          end
        end
      end
      STOP2: begin
        if (samp) begin
          tick_cnt_n = '0;
          ferr_n     = ferr | ~rx_s;
          state_n    = IDLE;
          push_vld_n = 1'b1;
          push_dat_n = {ferr | ~rx_s, perr, shift};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= IDLE;
      presc_cnt  <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      push_vld   <= 1'b0;
      push_dat   <= '0;
      presc_l    <= '0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      two_stop_l <= 1'b0;
    end else begin
      state     <= state_n;
      presc_cnt <= presc_cnt_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      perr      <= perr_n;
      ferr      <= ferr_n;
      push_vld  <= push_vld_n;
      push_dat  <= push_dat_n;
      if (latch_cfg) begin
        presc_l    <= prescale;
        par_en_l   <= parity_en;
        par_odd_l  <= parity_odd;
        two_stop_l <= two_stop;
      end
    end
  end

  assign rx_busy  = (state != IDLE);
  assign rd_valid = (fifo_level != '0);
  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign push_ok  = push_vld && ((fifo_level < DEPTH_L) || pop);

  always_ff @(posedge HCLK) begin
    if (HRESETn && push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (push_vld && !push_ok) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign head    = mem[rd_ptr];
  assign rd_data = rd_valid ? head[DATA_W-1:0] : '0;
  assign rd_perr = rd_valid ? head[DATA_W]     : 1'b0;
  assign rd_ferr = rd_valid ? head[DATA_W+1]   : 1'b0;

endmodule
